// File: rtl/btn_pkg.sv
// Shared width helpers and parameter legality rules for the button scanner.
package btn_pkg;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ch_w(input int num_btn);
    return idx_w(num_btn);
  endfunction

  // Per-channel agreement counter; only ever reaches STABLE_SAMPLES-1.
  function automatic int cnt_w(input int stable_samples);
    return (stable_samples > 1) ? $clog2(stable_samples + 1) : 1;
  endfunction

  function automatic bit params_ok(input int num_btn, input int tick_div,
                                   input int stable_samples);
    return (num_btn >= 1) && (tick_div >= 1) && (stable_samples >= 1);
  endfunction

endpackage

// File: rtl/button_scan_ctrl_tick_gen.sv
// Service-tick prescaler: one tick every TICK_DIV enabled cycles, count held while disabled.
module tick_gen
  import btn_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic enable_in,
  output logic tick_out
);

  localparam int PW = idx_w(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  if (TICK_DIV < 1) begin : g_bad_div
    $error("tick_gen: TICK_DIV must be >= 1");
  end

  assign tick_out = enable_in && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (enable_in) begin
      cnt_d = tick_out ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_scan_ctrl.sv
// Time-shared debouncer: one compare/count engine visits each channel in turn on prescaler ticks.
module button_scan_ctrl
  import btn_pkg::*;
#(
  parameter int NUM_BTN        = 8,
  parameter int TICK_DIV       = 1000,
  parameter int STABLE_SAMPLES = 16
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         enable_in,
  input  logic [NUM_BTN-1:0]           noisy_in,
  output logic [NUM_BTN-1:0]           clean_out,
  output logic [NUM_BTN-1:0]           press_out,
  output logic [NUM_BTN-1:0]           release_out,
  output logic [ch_w(NUM_BTN)-1:0]     chan_out,
  output logic                         scan_done_out
);

  localparam int CH_W  = ch_w(NUM_BTN);
  localparam int CNT_W = cnt_w(STABLE_SAMPLES);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_BTN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_SAMPLES - 1);

  if (!params_ok(NUM_BTN, TICK_DIV, STABLE_SAMPLES)) begin : g_bad_params
    $error("button_scan_ctrl: NUM_BTN, TICK_DIV and STABLE_SAMPLES must all be >= 1");
  end

  logic                tick;
  logic [NUM_BTN-1:0]  sync1_q, sync2_q;
  logic [NUM_BTN-1:0]  clean_q, press_q, release_q;
  logic [CH_W-1:0]     idx_q, idx_d, chan_q;
  logic                done_q;
  logic [CNT_W-1:0]    cnt_q [NUM_BTN];
  logic [CNT_W-1:0]    cnt_d;
  logic                cur_sync, cur_clean, expire;
  logic [CNT_W-1:0]    cur_cnt;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .enable_in(enable_in),
    .tick_out (tick)
  );

  // Shared engine: evaluate only the channel the scheduler points at.
  always_comb begin
    cur_sync  = sync2_q[idx_q];
    cur_clean = clean_q[idx_q];
    cur_cnt   = cnt_q[idx_q];
    expire    = (cur_sync != cur_clean) && (cur_cnt == LAST_CNT);
    cnt_d     = (cur_sync == cur_clean || expire) ? '0 : cur_cnt + CNT_W'(1);
    idx_d     = (idx_q == LAST_CH) ? '0 : idx_q + CH_W'(1);
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      clean_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      idx_q     <= '0;
      chan_q    <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // Synchronizer runs every cycle so sampled data is fresh on re-enable.
      sync1_q   <= noisy_in;
      sync2_q   <= sync1_q;
      press_q   <= '0;
      release_q <= '0;
      done_q    <= 1'b0;
      if (tick) begin
        chan_q       <= idx_q;
        idx_q        <= idx_d;
        cnt_q[idx_q] <= cnt_d;
        done_q       <= (idx_q == LAST_CH);
        if (expire) begin
          clean_q[idx_q]   <= cur_sync;
          press_q[idx_q]   <= cur_sync;
          release_q[idx_q] <= ~cur_sync;
        end
      end
    end
  end

  assign clean_out     = clean_q;
  assign press_out     = press_q;
  assign release_out   = release_q;
  assign chan_out      = chan_q;
  assign scan_done_out = done_q;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl with a cycle-level reference model (4 channels, div 4, 3 samples).
module tb_button_scan_ctrl;
  localparam int NB = 4;
  localparam int TD = 4;
  localparam int SS = 3;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic          enable_in;
  logic [NB-1:0] noisy_in;
  logic [NB-1:0] clean_out, press_out, release_out;
  logic [1:0]    chan_out;
  logic          scan_done_out;

  always #5 clock_in = ~clock_in;

  button_scan_ctrl #(.NUM_BTN(NB), .TICK_DIV(TD), .STABLE_SAMPLES(SS)) dut (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .enable_in    (enable_in),
    .noisy_in     (noisy_in),
    .clean_out    (clean_out),
    .press_out    (press_out),
    .release_out  (release_out),
    .chan_out     (chan_out),
    .scan_done_out(scan_done_out)
  );

  // Reference: enabled-cycle counting, round-robin visits, visit tally per channel.
  int            m_pre, m_next, m_visits[NB];
  logic [NB-1:0] m_clean, m_press, m_rel, m_seen1, m_seen2;
  logic [1:0]    m_chan;
  logic          m_done;

  always @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      m_pre = 0; m_next = 0; m_clean = '0; m_press = '0; m_rel = '0;
      m_seen1 = '0; m_seen2 = '0; m_chan = '0; m_done = 1'b0;
      for (int i = 0; i < NB; i++) m_visits[i] = 0;
    end else begin
      m_press = '0; m_rel = '0; m_done = 1'b0;
      if (enable_in) begin
        m_pre = m_pre + 1;
        if (m_pre == TD) begin
          int c;
          m_pre = 0;
          c = m_next;
          m_chan = 2'(c);
          if (m_seen2[c] == m_clean[c]) m_visits[c] = 0;
          else begin
            m_visits[c] = m_visits[c] + 1;
            if (m_visits[c] == SS) begin
              m_clean[c] = m_seen2[c];
              if (m_seen2[c]) m_press[c] = 1'b1; else m_rel[c] = 1'b1;
              m_visits[c] = 0;
            end
          end
          m_next = (c + 1) % NB;
          m_done = (c == NB - 1);
        end
      end
      m_seen2 = m_seen1;
      m_seen1 = noisy_in;
    end
  end

  int vectors = 0, miscompares = 0, cycle = 0;
  int pcnt[NB], rcnt[NB], ptime[NB];
  int last_done = -1, done_gap = 0;

  task automatic cyc();
    @(posedge clock_in);
    #1;
    cycle++;
    vectors++;
    if ({clean_out, press_out, release_out, chan_out, scan_done_out} !==
        {m_clean, m_press, m_rel, m_chan, m_done}) begin
      miscompares++;
      $display("FAIL model cyc%0d: dut c=%b p=%b r=%b ch=%0d d=%b want c=%b p=%b r=%b ch=%0d d=%b",
               cycle, clean_out, press_out, release_out, chan_out, scan_done_out,
               m_clean, m_press, m_rel, m_chan, m_done);
    end
    for (int i = 0; i < NB; i++) begin
      if (press_out[i]) begin pcnt[i]++; ptime[i] = cycle; end
      if (release_out[i]) rcnt[i]++;
    end
    if (scan_done_out) begin
      if (last_done >= 0) done_gap = cycle - last_done;
      last_done = cycle;
    end
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    cycn(2);
    reset_in = 1'b0;
    last_done = -1;
  endtask

  task automatic wait_clean(input int ch, input logic val, input int limit);
    int n;
    n = 0;
    while (clean_out[ch] !== val && n < limit) begin
      cyc();
      n++;
    end
  endtask

  int snap_p[NB], snap_r[NB], t[NB], tmp, ndone;
  logic [NB-1:0] held;

  initial begin
    for (int i = 0; i < NB; i++) begin pcnt[i] = 0; rcnt[i] = 0; ptime[i] = 0; end
    reset_in = 1'b0; enable_in = 1'b1; noisy_in = 4'b1111;
    #1 reset_in = 1'b1;
    // 1: reset with all inputs high, then first-tick timing
    cycn(2);
    check("reset_clean", int'(clean_out), 0);
    check("reset_pulses", int'({press_out, release_out, scan_done_out}), 0);
    check("reset_chan", int'(chan_out), 0);
    reset_in = 1'b0;
    cycn(7);
    check("chan_edge7", int'(chan_out), 0);
    cyc();
    check("chan_edge8", int'(chan_out), 1);
    cycn(27);
    check("clean_edge35", int'(clean_out), 0);
    cyc();
    check("clean_edge36", int'(clean_out), 4'b0001);
    check("press_edge36", int'(press_out), 4'b0001);

    // 2: single held button
    noisy_in = 4'b0000;
    do_reset();
    cycn(40);
    for (int i = 0; i < NB; i++) begin snap_p[i] = pcnt[i]; snap_r[i] = rcnt[i]; end
    noisy_in = 4'b0100;
    wait_clean(2, 1'b1, 66);
    cycn(5);
    check("t2_clean", int'(clean_out), 4'b0100);
    check("t2_press2", pcnt[2] - snap_p[2], 1);
    check("t2_release", rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3] -
          (snap_r[0] + snap_r[1] + snap_r[2] + snap_r[3]), 0);

    // 3: glitch shorter than the debounce window
    for (int i = 0; i < NB; i++) begin snap_p[i] = pcnt[i]; snap_r[i] = rcnt[i]; end
    noisy_in = 4'b0110;
    cycn(20);
    noisy_in = 4'b0100;
    cycn(40);
    check("t3_clean", int'(clean_out), 4'b0100);
    check("t3_pulses1", (pcnt[1] - snap_p[1]) + (rcnt[1] - snap_r[1]), 0);

    // 4: all inputs rise together
    noisy_in = 4'b0000;
    do_reset();
    cycn(37);
    for (int i = 0; i < NB; i++) snap_p[i] = pcnt[i];
    noisy_in = 4'b1111;
    tmp = 0;
    while (clean_out !== 4'b1111 && tmp < 90) begin cyc(); tmp++; end
    cycn(3);
    check("t4_clean", int'(clean_out), 4'b1111);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("t4_press%0d", i), pcnt[i] - snap_p[i], 1);
      t[i] = ptime[i];
    end
    for (int i = 0; i < NB - 1; i++)
      for (int j = 0; j < NB - 1 - i; j++)
        if (t[j] > t[j+1]) begin tmp = t[j]; t[j] = t[j+1]; t[j+1] = tmp; end
    for (int i = 0; i < NB - 1; i++) check($sformatf("t4_gap%0d", i), t[i+1] - t[i], TD);

    // 5: release one channel, then scan-done cadence
    for (int i = 0; i < NB; i++) snap_r[i] = rcnt[i];
    noisy_in = 4'b1110;
    wait_clean(0, 1'b0, 66);
    cycn(3);
    check("t5_clean", int'(clean_out), 4'b1110);
    check("t5_release0", rcnt[0] - snap_r[0], 1);
    ndone = 0; tmp = 0;
    while (ndone < 2 && tmp < 40) begin
      cyc(); tmp++;
      if (scan_done_out) ndone++;
    end
    check("t5_done_seen", ndone, 2);
    check("t5_done_gap", done_gap, NB * TD);

    // 6a: freeze mid-count with enable low
    for (int i = 0; i < NB; i++) snap_p[i] = pcnt[i];
    noisy_in = 4'b1111;
    cycn(20);
    check("t6_pre_freeze", int'(clean_out[0]), 0);
    enable_in = 1'b0;
    held = clean_out;
    cycn(100);
    check("t6_frozen_clean", int'(clean_out), int'(held));
    check("t6_frozen_press", pcnt[0] - snap_p[0], 0);
    enable_in = 1'b1;
    wait_clean(0, 1'b1, 32);
    check("t6_resume_clean", int'(clean_out[0]), 1);
    cycn(2);
    check("t6_resume_press", pcnt[0] - snap_p[0], 1);

    // 6b: reset mid-count discards progress
    noisy_in = 4'b0000;
    do_reset();
    cycn(40);
    noisy_in = 4'b0010;
    cycn(20);
    check("t6b_pre_reset", int'(clean_out[1]), 0);
    do_reset();
    cycn(39);
    check("t6b_edge39", int'(clean_out[1]), 0);
    cyc();
    check("t6b_edge40_clean", int'(clean_out), 4'b0010);
    check("t6b_edge40_press", int'(press_out), 4'b0010);
    cycn(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
